// File: rtl/sqw_pkg.sv
// sqw_pkg: shared types and defaults for the square-wave meter.
//   sqw_state_t        measurement FSM state encoding
//   DEF_CNT_W          default phase-counter width
//   DEF_TIMEOUT_CYCLES default cycles without an edge before timeout
//   DEGLITCH_LEN       consecutive equal samples needed by the optional
//                      deglitch filter (SQW_DEGLITCH_EN)
package sqw_pkg;

    typedef enum logic [1:0] {
        WAIT_RISE = 2'd0,
        MEAS_HIGH = 2'd1,
        MEAS_LOW  = 2'd2
    } sqw_state_t;

    localparam int DEF_CNT_W          = 16;
    localparam int DEF_TIMEOUT_CYCLES = 65535;
    localparam int DEGLITCH_LEN       = 3;

endpackage

// File: rtl/sqw_edge_sync.sv
// sqw_edge_sync: brings the asynchronous square wave into the clock domain
// and produces single-cycle rise/fall strobes.
//   i_clk      system clock
//   i_reset_n  asynchronous active-low reset
//   i_sq_in    asynchronous square wave
//   o_level    synchronized (and optionally filtered) level
//   o_rise     one-cycle strobe on a 0->1 change of o_level
//   o_fall     one-cycle strobe on a 1->0 change of o_level
// Build option: define SQW_DEGLITCH_EN to insert a DEGLITCH_LEN-sample
// stability filter after the synchronizer (adds 2 cycles of edge latency,
// swallows pulses shorter than DEGLITCH_LEN cycles).
module sqw_edge_sync
    import sqw_pkg::*;
(
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_sq_in,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;
    logic w_level;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_sq_in;
            r_sync2 <= r_sync1;
        end
    end

`ifdef SQW_DEGLITCH_EN
    // r_hist holds the previous DEGLITCH_LEN-1 synced samples; the level
    // follows r_sync2 only when the whole window agrees, otherwise it holds.
    logic [DEGLITCH_LEN-2:0] r_hist;
    logic                    r_held;
    logic                    w_stable;

    assign w_stable = (&{r_sync2, r_hist}) | ~(|{r_sync2, r_hist});
    assign w_level  = w_stable ? r_sync2 : r_held;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_hist <= '0;
            r_held <= 1'b0;
        end else begin
            r_hist <= {r_hist[DEGLITCH_LEN-3:0], r_sync2};
            r_held <= w_level;
        end
    end
`else
    assign w_level = r_sync2;
`endif

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= w_level;
        end
    end

    assign o_level = w_level;
    assign o_rise  = w_level & ~r_prev;
    assign o_fall  = ~w_level & r_prev;

endmodule

// File: rtl/square_wave_meter.sv
// square_wave_meter: measures high time, low time and period of an
// asynchronous square wave in clock cycles.
//   i_clk          system clock
//   i_reset_n      asynchronous active-low reset
//   i_sq_in        asynchronous square wave under measurement
//   o_high_count   high cycles of the last complete period
//   o_low_count    low cycles of the last complete period
//   o_period       o_high_count + o_low_count
//   o_meas_valid   one-cycle pulse when the three counts update
//   o_locked       a full period has been measured since reset/timeout
//   o_timeout      sticky: no edge for TIMEOUT_CYCLES cycles
// Build option: SQW_DEGLITCH_EN (see sqw_edge_sync).
//
// state     | meaning
// ----------+-----------------------------------------------------------
// WAIT_RISE | discarding the partial phase, waiting for the first rise
// MEAS_HIGH | counting the high phase, fall latches it into r_hold
// MEAS_LOW  | counting the low phase, rise publishes a measurement
module square_wave_meter
    import sqw_pkg::*;
#(
    parameter int SYSCLK_MHZ     = 100,
    parameter int CNT_W          = DEF_CNT_W,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_sq_in,
    output logic [CNT_W-1:0] o_high_count,
    output logic [CNT_W-1:0] o_low_count,
    output logic [CNT_W:0]   o_period,
    output logic             o_meas_valid,
    output logic             o_locked,
    output logic             o_timeout
);

    // The timeout compare must be reachable by the saturating counter.
    if (SYSCLK_MHZ < 1 || TIMEOUT_CYCLES < 1 ||
        $clog2(TIMEOUT_CYCLES + 1) > CNT_W) begin : g_bad_param
        $error("square_wave_meter: bad SYSCLK_MHZ/TIMEOUT_CYCLES/CNT_W");
    end

    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

    sqw_state_t       r_state;
    sqw_state_t       w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_hold;
    logic [CNT_W-1:0] w_phase_len;
    logic             w_level;
    logic             w_rise;
    logic             w_fall;
    logic             w_edge;
    logic             w_tmo_hit;
    logic             w_cap_high;
    logic             w_publish;

    sqw_edge_sync u_edge_sync (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_sq_in   (i_sq_in),
        .o_level   (w_level),
        .o_rise    (w_rise),
        .o_fall    (w_fall)
    );

    // Direction of an edge is read from the settled level.
    assign w_edge      = w_rise | w_fall;
    // An edge in the terminal-count cycle wins over the timeout.
    assign w_tmo_hit   = (r_cnt == TIMEOUT_VAL) && !w_edge;
    assign w_phase_len = (r_cnt == CNT_MAX) ? CNT_MAX : r_cnt + CNT_W'(1);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= WAIT_RISE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cap_high   = 1'b0;
        w_publish    = 1'b0;
        if (w_tmo_hit) begin
            w_state_next = WAIT_RISE;
        end else begin
            case (r_state)
                WAIT_RISE: begin
                    if (w_edge && w_level) begin
                        w_state_next = MEAS_HIGH;
                    end
                end
                MEAS_HIGH: begin
                    if (w_edge && !w_level) begin
                        w_cap_high   = 1'b1;
                        w_state_next = MEAS_LOW;
                    end
                end
                MEAS_LOW: begin
                    if (w_edge && w_level) begin
                        w_publish    = 1'b1;
                        w_state_next = MEAS_HIGH;
                    end
                end
                default: w_state_next = WAIT_RISE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_cnt <= '0;
        end else if (w_edge || w_tmo_hit) begin
            r_cnt <= '0;
        end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_hold <= '0;
        end else if (w_cap_high) begin
            r_hold <= w_phase_len;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_high_count <= '0;
            o_low_count  <= '0;
            o_period     <= '0;
            o_meas_valid <= 1'b0;
            o_locked     <= 1'b0;
            o_timeout    <= 1'b0;
        end else begin
            o_meas_valid <= w_publish;
            if (w_publish) begin
                o_high_count <= r_hold;
                o_low_count  <= w_phase_len;
                o_period     <= {1'b0, r_hold} + {1'b0, w_phase_len};
                o_locked     <= 1'b1;
                o_timeout    <= 1'b0;
            end else if (w_tmo_hit) begin
                o_locked     <= 1'b0;
                o_timeout    <= 1'b1;
            end
        end
    end

endmodule
